// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver: FSM states, JK drive codes and the
// excitation function that maps a q transition onto a {j,k} pair.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_FLUSH
  } state_e;

  typedef logic [1:0] jk_code_t;

  localparam jk_code_t JK_HOLD   = 2'b00;
  localparam jk_code_t JK_RESET  = 2'b01;
  localparam jk_code_t JK_SET    = 2'b10;
  localparam jk_code_t JK_TOGGLE = 2'b11;

  // The don't-care in each JK excitation entry is resolved towards hold/set/reset
  // codes (toggle_pref=0) or towards toggle-heavy codes (toggle_pref=1).
  function automatic jk_code_t jk_excite(input logic q, input logic q_next,
                                         input logic toggle_pref);
    if (toggle_pref) begin
      if (q != q_next) return JK_TOGGLE;
      return q_next ? JK_SET : JK_RESET;
    end
    if (q == q_next) return JK_HOLD;
    return q_next ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/jk_excitation_driver.sv
// Drives a jkff so its q follows a latched WIDTH-bit pattern (bit 0 first),
// and counts cycles where the fed-back q disagrees with the expected sequence.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit TOGGLE_PREF = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           pattern,
  input  logic                       pattern_valid,
  output logic                       ready,
  output logic                       j,
  output logic                       k,
  input  logic                       q_fb,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+2)-1:0] mismatch_cnt,
  output logic                       pass
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int IDX_W = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic              shadow_q, shadow_d;
  logic              shadow_dly_q, shadow_dly_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  jk_code_t          jk_q, jk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              check_en;

  // q_fb lags the issued bit by one more edge than the shadow, hence the delay.
  assign check_en = (state_q == ST_RUN) || (state_q == ST_FLUSH);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default in always_comb would infer a latch.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    shadow_d     = shadow_q;
    shadow_dly_d = shadow_q;
    idx_d        = idx_q;
    jk_d         = jk_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    done_d       = 1'b0;

    if (check_en && (q_fb != shadow_dly_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pattern_valid) begin
          pat_d    = pattern;
          cnt_d    = '0;
          pass_d   = 1'b0;
          jk_d     = JK_RESET;
          shadow_d = 1'b0;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        jk_d     = jk_excite(1'b0, pat_q[0], TOGGLE_PREF);
        shadow_d = pat_q[0];
        idx_d    = IDX_W'(1);
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        jk_d     = jk_excite(shadow_q, pat_q[idx_q], TOGGLE_PREF);
        shadow_d = pat_q[idx_q];
        if (idx_q == IDX_W'(WIDTH - 1)) begin
          idx_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_FLUSH: begin
        // idx doubles as the two-cycle flush counter.
        jk_d = JK_HOLD;
        if (idx_q == IDX_W'(1)) begin
          idx_d   = '0;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      // NOTE: the pattern register is reset too; it is only WIDTH flops and a
      // known value keeps post-reset behaviour deterministic.
      pat_q        <= '0;
      shadow_q     <= 1'b0;
      shadow_dly_q <= 1'b0;
      idx_q        <= '0;
      jk_q         <= JK_HOLD;
      cnt_q        <= '0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      shadow_q     <= shadow_d;
      shadow_dly_q <= shadow_dly_d;
      idx_q        <= idx_d;
      jk_q         <= jk_d;
      cnt_q        <= cnt_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
    end
  end

  assign ready        = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign j            = jk_q[1];
  assign k            = jk_q[0];
  assign done         = done_q;
  assign mismatch_cnt = cnt_q;
  assign pass         = pass_q;

endmodule
